// File: rtl/mmio_serial_pkg.sv
// Shared constants and state encodings for the memory-mapped serial port.
// Building with MMIO_PARITY_EN adds PARITY states to both FSMs (8E1 framing).
package mmio_serial_pkg;

  localparam logic [1:0] WIN_WR      = 2'b01;
  localparam logic [1:0] WIN_RD      = 2'b10;
  localparam logic [1:0] OFS_DATA    = 2'd0;
  localparam logic [1:0] OFS_CTRL_RX = 2'd1;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_VALID   = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_OVF     = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_PARITY_ERR = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef MMIO_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef MMIO_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rxState_t;

endpackage

// File: rtl/mmio_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through; pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
module mmio_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        w_doPush;
  logic        w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_dout   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mmio_serial_port.sv
// MMIO UART responder: stores feed a TX FIFO serialized as 8N1 on ja[0], loads
// return status or the received byte combinationally. MMIO_PARITY_EN selects 8E1.
module mmio_serial_port
  import mmio_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_insn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rx_in,
  output logic [5:0]  ja
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       w_wrAcc, w_rdAcc, w_push, w_ctrlClr, w_rxRead;
  logic [1:0] w_ofs;
  logic       w_full, w_empty, w_pop, w_txBusy, w_txBitEnd, w_rxBitEnd;
  logic [7:0] w_dout, w_status;
  logic       w_parityErr;
  logic       w_unused;

  txState_t      r_txState;
  logic [CW-1:0] r_txCnt;
  logic [2:0]    r_txBit;
  logic [7:0]    r_txShift;
  logic          r_txLine, r_txOvf;

  rxState_t      r_rxState;
  logic [CW-1:0] r_rxCnt;
  logic [2:0]    r_rxBit;
  logic [7:0]    r_rxShift, r_rxData;
  logic          r_sync1, r_sync2, r_rxValid, r_rxOvf, r_frameErr;

  assign w_ofs     = mem_addr[3:2];
  assign w_wrAcc   = io_insn && (mem_addr[13:12] == WIN_WR);
  assign w_rdAcc   = io_insn && (mem_addr[13:12] == WIN_RD);
  assign w_push    = w_wrAcc && (w_ofs == OFS_DATA);
  assign w_ctrlClr = w_wrAcc && (w_ofs == OFS_CTRL_RX) && data_in[0];
  assign w_rxRead  = w_rdAcc && (w_ofs == OFS_CTRL_RX);
  assign w_unused  = ^{mem_addr[31:14], mem_addr[11:4], mem_addr[1:0], data_in[31:8]};

  mmio_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data_in[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Popping at the end of STOP lets queued frames follow with no idle gap.
  assign w_txBitEnd = (r_txCnt == BIT_LAST);
  assign w_pop      = !w_empty && ((r_txState == TX_IDLE) || ((r_txState == TX_STOP) && w_txBitEnd));
  assign w_txBusy   = (r_txState != TX_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_txLine  <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: if (w_pop) begin
          r_txShift <= w_dout;
          r_txLine  <= 1'b0;
          r_txCnt   <= '0;
          r_txState <= TX_START;
        end
        TX_START: if (w_txBitEnd) begin
          r_txCnt   <= '0;
          r_txBit   <= '0;
          r_txLine  <= r_txShift[0];
          r_txState <= TX_DATA;
        end else r_txCnt <= r_txCnt + 1'b1;
        TX_DATA: if (w_txBitEnd) begin
          r_txCnt <= '0;
          if (r_txBit == 3'd7) begin
`ifdef MMIO_PARITY_EN
            r_txLine  <= ^r_txShift;
            r_txState <= TX_PARITY;
`else
            r_txLine  <= 1'b1;
            r_txState <= TX_STOP;
`endif
          end else begin
            r_txBit  <= r_txBit + 3'd1;
            r_txLine <= r_txShift[r_txBit + 3'd1];
          end
        end else r_txCnt <= r_txCnt + 1'b1;
`ifdef MMIO_PARITY_EN
        TX_PARITY: if (w_txBitEnd) begin
          r_txCnt   <= '0;
          r_txLine  <= 1'b1;
          r_txState <= TX_STOP;
        end else r_txCnt <= r_txCnt + 1'b1;
`endif
        TX_STOP: if (w_txBitEnd) begin
          r_txCnt <= '0;
          if (w_pop) begin
            r_txShift <= w_dout;
            r_txLine  <= 1'b0;
            r_txState <= TX_START;
          end else r_txState <= TX_IDLE;
        end else r_txCnt <= r_txCnt + 1'b1;
        default: r_txState <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                    r_txOvf <= 1'b0;
    else if (w_push && w_full)    r_txOvf <= 1'b1;
    else if (w_ctrlClr)           r_txOvf <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxBitEnd = (r_rxCnt == BIT_LAST);

`ifdef MMIO_PARITY_EN
  logic r_parityErr;
  assign w_parityErr = r_parityErr;
`else
  assign w_parityErr = 1'b0;
`endif

  // Clears are issued first so that a flag or byte set later in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxBit    <= '0;
      r_rxShift  <= '0;
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_rxOvf    <= 1'b0;
      r_frameErr <= 1'b0;
`ifdef MMIO_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      if (w_ctrlClr) begin
        r_rxOvf    <= 1'b0;
        r_frameErr <= 1'b0;
`ifdef MMIO_PARITY_EN
        r_parityErr <= 1'b0;
`endif
      end
      if (w_rxRead) r_rxValid <= 1'b0;
      case (r_rxState)
        RX_IDLE: if (!r_sync2) begin
          r_rxCnt   <= '0;
          r_rxState <= RX_START;
        end
        RX_START: if (r_rxCnt == HALF_LAST) begin
          r_rxCnt <= '0;
          r_rxBit <= '0;
          r_rxState <= r_sync2 ? RX_IDLE : RX_DATA;
        end else r_rxCnt <= r_rxCnt + 1'b1;
        RX_DATA: if (w_rxBitEnd) begin
          r_rxCnt   <= '0;
          r_rxShift <= {r_sync2, r_rxShift[7:1]};
          r_rxBit   <= r_rxBit + 3'd1;
`ifdef MMIO_PARITY_EN
          if (r_rxBit == 3'd7) r_rxState <= RX_PARITY;
`else
          if (r_rxBit == 3'd7) r_rxState <= RX_STOP;
`endif
        end else r_rxCnt <= r_rxCnt + 1'b1;
`ifdef MMIO_PARITY_EN
        RX_PARITY: if (w_rxBitEnd) begin
          r_rxCnt   <= '0;
          r_rxState <= RX_STOP;
          if (r_sync2 != ^r_rxShift) r_parityErr <= 1'b1;
        end else r_rxCnt <= r_rxCnt + 1'b1;
`endif
        RX_STOP: if (w_rxBitEnd) begin
          r_rxCnt   <= '0;
          r_rxState <= RX_IDLE;
          if (r_sync2) begin
            r_rxData  <= r_rxShift;
            r_rxValid <= 1'b1;
            if (r_rxValid && !w_rxRead) r_rxOvf <= 1'b1;
          end else r_frameErr <= 1'b1;
        end else r_rxCnt <= r_rxCnt + 1'b1;
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[ST_TX_EMPTY]   = w_empty;
    w_status[ST_TX_FULL]    = w_full;
    w_status[ST_TX_BUSY]    = w_txBusy;
    w_status[ST_RX_VALID]   = r_rxValid;
    w_status[ST_TX_OVF]     = r_txOvf;
    w_status[ST_RX_OVF]     = r_rxOvf;
    w_status[ST_FRAME_ERR]  = r_frameErr;
    w_status[ST_PARITY_ERR] = w_parityErr;
    data_out = '0;
    if (w_rdAcc) begin
      case (w_ofs)
        OFS_DATA:    data_out = {24'b0, w_status};
        OFS_CTRL_RX: data_out = {24'b0, r_rxData};
        default:     data_out = '0;
      endcase
    end
  end

  assign ja = {2'b00, r_rxValid, w_full, w_txBusy, r_txLine};

endmodule

// File: tb/tb_mmio_serial_port.sv
// Self-checking bench for mmio_serial_port: random bytes and addresses checked
// against a frame-level UART model and a flag model kept in the bench.
module tb_mmio_serial_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef MMIO_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam logic [63:0] FMASK = (64'd1 << FRAME) - 64'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_insn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] data_in = '0;
  logic        rx_in = 1'b1;
  wire  [31:0] data_out;
  wire  [5:0]  ja;

  int total = 0;
  int bad = 0;

  logic       mRxValid, mRxOvf, mFrameErr, mTxOvf;
  logic [7:0] mRxData;

  mmio_serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_insn  (io_insn),
    .mem_addr (mem_addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rx_in    (rx_in),
    .ja       (ja)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bit idx of a UART frame carrying d: start, LSB-first data, optional even parity, stop.
  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == NBITS - 1) return 1'b1;
    return ^d;
  endfunction

  function automatic logic [31:0] mkAddr(input logic [1:0] win, input logic [1:0] ofs);
    logic [31:0] a;
    a = $urandom;
    a[13:12] = win;
    a[3:2] = ofs;
    return a;
  endfunction

  function automatic logic [31:0] idleStatus();
    return {24'b0, 1'b0, mFrameErr, mRxOvf, mTxOvf, mRxValid, 3'b001};
  endfunction

  function automatic void resetModel();
    mRxValid = 1'b0; mRxOvf = 1'b0; mFrameErr = 1'b0; mTxOvf = 1'b0; mRxData = 8'h00;
  endfunction

  function automatic void rxModel(input logic [7:0] d, input logic stopBit);
    if (stopBit) begin
      if (mRxValid) mRxOvf = 1'b1;
      mRxData = d;
      mRxValid = 1'b1;
    end else mFrameErr = 1'b1;
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clock); #1;
    io_insn = 1'b1; mem_addr = addr; data_in = data;
    @(posedge clock); #1;
    io_insn = 1'b0; mem_addr = '0; data_in = '0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] val);
    @(posedge clock); #1;
    io_insn = 1'b1; mem_addr = addr; data_in = $urandom;
    @(negedge clock);
    val = data_out;
    @(posedge clock); #1;
    io_insn = 1'b0; mem_addr = '0; data_in = '0;
  endtask

  task automatic storeBurst(input logic [7:0] first, input int n);
    @(posedge clock); #1;
    io_insn = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_addr = mkAddr(2'b01, 2'd0);
      data_in = {24'($urandom), first + 8'(i)};
      @(posedge clock); #1;
    end
    io_insn = 1'b0; mem_addr = '0; data_in = '0;
  endtask

  task automatic driveRx(input logic [7:0] d, input logic stopBit);
    @(posedge clock); #1;
    for (int idx = 0; idx < NBITS; idx++) begin
      rx_in = (idx == NBITS - 1) ? stopBit : frameBit(d, idx);
      repeat (CPB) @(posedge clock);
      #1;
    end
    rx_in = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic waitLineLow(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ja[0] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic captureFrame(input logic [7:0] d);
    bit found;
    logic [63:0] obs, expv, busy;
    waitLineLow(4, found);
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL tx_start byte=%02h: line stayed high, required low within 4 cycles", d);
      return;
    end
    obs = '0; expv = '0; busy = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clock);
      obs[i] = ja[0];
      busy[i] = ja[1];
      expv[i] = frameBit(d, i / CPB);
    end
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL tx_frame byte=%02h: got %h required %h", d, obs, expv);
    end
    total++;
    if (busy !== FMASK) begin
      bad++;
      $display("[TB] FAIL tx_busy byte=%02h: got %h required %h", d, busy, FMASK);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    resetModel();
    @(negedge clock);
    total++;
    if (ja !== 6'b000001) begin
      bad++; $display("[TB] FAIL reset_ja: got %b required 000001", ja);
    end
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_dout_idle: got %h required 0", data_out);
    end
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== 32'h1) begin
      bad++; $display("[TB] FAIL reset_status: got %h required 00000001", v);
    end
    readReg(mkAddr(2'b10, 2'd1), v);
    total++;
    if (v !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rxdata: got %h required 0", v);
    end
  endtask

  task automatic test_tx();
    logic [7:0] d;
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom);
      applyStimulus(mkAddr(2'b01, 2'd0), {24'($urandom), d});
      captureFrame(d);
      readReg(mkAddr(2'b10, 2'd0), v);
      total++;
      if (v !== idleStatus()) begin
        bad++; $display("[TB] FAIL tx_idle_status byte=%02h: got %h required %h", d, v, idleStatus());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lead;
    logic [31:0] v, expv;
    lead = 8'($urandom);
    applyStimulus(mkAddr(2'b01, 2'd0), {24'($urandom), lead});
    fork
      begin
        bit found;
        int mism, firstBad;
        logic [7:0] b;
        logic e;
        mism = 0; firstBad = -1;
        waitLineLow(6, found);
        total++;
        if (!found) begin
          bad++; $display("[TB] FAIL b2b_start: line stayed high, required low within 6 cycles");
        end else begin
          for (int i = 0; i < 9 * FRAME + 8; i++) begin
            if (i > 0) @(negedge clock);
            if (i < 9 * FRAME) begin
              b = (i / FRAME == 0) ? lead : 8'(i / FRAME);
              e = frameBit(b, (i % FRAME) / CPB);
            end else e = 1'b1;
            if (ja[0] !== e) begin
              mism++;
              if (firstBad < 0) firstBad = i;
            end
          end
          total++;
          if (mism != 0) begin
            bad++; $display("[TB] FAIL b2b_stream: %0d cycles wrong (first at %0d), required 0", mism, firstBad);
          end
        end
      end
      begin
        storeBurst(8'h01, 9);
        mTxOvf = 1'b1;
        readReg(mkAddr(2'b10, 2'd0), v);
        expv = {24'b0, 1'b0, mFrameErr, mRxOvf, 1'b1, mRxValid, 3'b110};
        total++;
        if (v !== expv) begin
          bad++; $display("[TB] FAIL b2b_ovf_status: got %h required %h", v, expv);
        end
      end
    join
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL b2b_after_status: got %h required %h", v, idleStatus());
    end
    applyStimulus(mkAddr(2'b01, 2'd1), {$urandom} & 32'hFFFF_FFFE);
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL ctrl_noclear: got %h required %h", v, idleStatus());
    end
    applyStimulus(mkAddr(2'b01, 2'd1), {$urandom} | 32'h1);
    mTxOvf = 1'b0; mRxOvf = 1'b0; mFrameErr = 1'b0;
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL ctrl_clear: got %h required %h", v, idleStatus());
    end
  endtask

  task automatic test_rx();
    logic [31:0] v;
    driveRx(8'h3C, 1'b1);
    rxModel(8'h3C, 1'b1);
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL rx_valid_status: got %h required %h", v, idleStatus());
    end
    readReg(mkAddr(2'b10, 2'd1), v);
    total++;
    if (v !== {24'b0, mRxData}) begin
      bad++; $display("[TB] FAIL rx_data: got %h required %h", v, {24'b0, mRxData});
    end
    mRxValid = 1'b0;
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL rx_cleared_status: got %h required %h", v, idleStatus());
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] v;
    driveRx(8'h11, 1'b1); rxModel(8'h11, 1'b1);
    driveRx(8'h22, 1'b1); rxModel(8'h22, 1'b1);
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL rx_ovf_status: got %h required %h", v, idleStatus());
    end
    begin
      logic [7:0] d;
      d = 8'($urandom);
      driveRx(d, 1'b0); rxModel(d, 1'b0);
    end
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL frame_err_status: got %h required %h", v, idleStatus());
    end
    readReg(mkAddr(2'b10, 2'd1), v);
    total++;
    if (v !== {24'b0, mRxData}) begin
      bad++; $display("[TB] FAIL frame_err_rxdata: got %h required %h", v, {24'b0, mRxData});
    end
    mRxValid = 1'b0;
    applyStimulus(mkAddr(2'b01, 2'd1), 32'h1);
    mRxOvf = 1'b0; mFrameErr = 1'b0; mTxOvf = 1'b0;
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL rx_ctrl_clear: got %h required %h", v, idleStatus());
    end
  endtask

  task automatic test_rx_random();
    logic [31:0] v;
    logic [7:0] d;
    logic stopBit;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      stopBit = ($urandom_range(0, 3) != 0);
      driveRx(d, stopBit);
      rxModel(d, stopBit);
      if ($urandom_range(0, 1) == 1) begin
        readReg(mkAddr(2'b10, 2'd1), v);
        total++;
        if (v !== {24'b0, mRxData}) begin
          bad++; $display("[TB] FAIL rx_rand_data k=%0d: got %h required %h", k, v, {24'b0, mRxData});
        end
        mRxValid = 1'b0;
      end else begin
        readReg(mkAddr(2'b10, 2'd0), v);
        total++;
        if (v !== idleStatus()) begin
          bad++; $display("[TB] FAIL rx_rand_status k=%0d: got %h required %h", k, v, idleStatus());
        end
      end
    end
  endtask

  task automatic test_ignored_window();
    logic [31:0] v;
    logic [7:0] d;
    d = 8'($urandom);
    driveRx(d, 1'b1); rxModel(d, 1'b1);
    for (int o = 0; o < 4; o++) begin
      applyStimulus(mkAddr(2'b11, 2'(o)), $urandom | 32'h1);
      readReg(mkAddr(2'b11, 2'(o)), v);
      total++;
      if (v !== 32'h0) begin
        bad++; $display("[TB] FAIL win11_read ofs=%0d: got %h required 0", o, v);
      end
    end
    applyStimulus(mkAddr(2'b01, 2'd2), $urandom | 32'h1);
    applyStimulus(mkAddr(2'b01, 2'd3), $urandom | 32'h1);
    for (int o = 2; o < 4; o++) begin
      readReg(mkAddr(2'b10, 2'(o)), v);
      total++;
      if (v !== 32'h0) begin
        bad++; $display("[TB] FAIL rd_reserved ofs=%0d: got %h required 0", o, v);
      end
    end
    @(negedge clock);
    total++;
    if (ja !== 6'b001001) begin
      bad++; $display("[TB] FAIL ignored_ja: got %b required 001001", ja);
    end
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== idleStatus()) begin
      bad++; $display("[TB] FAIL ignored_status: got %h required %h", v, idleStatus());
    end
    readReg(mkAddr(2'b10, 2'd1), v);
    total++;
    if (v !== {24'b0, mRxData}) begin
      bad++; $display("[TB] FAIL ignored_rxdata: got %h required %h", v, {24'b0, mRxData});
    end
    mRxValid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int lows;
    applyStimulus(mkAddr(2'b01, 2'd0), 32'($urandom));
    applyStimulus(mkAddr(2'b01, 2'd0), 32'($urandom));
    repeat ($urandom_range(4, 30)) @(posedge clock);
    #1;
    total++;
    if (ja[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL midframe_busy: got %b required 1", ja[1]);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    resetModel();
    @(negedge clock);
    total++;
    if (ja !== 6'b000001) begin
      bad++; $display("[TB] FAIL midframe_reset_ja: got %b required 000001", ja);
    end
    readReg(mkAddr(2'b10, 2'd0), v);
    total++;
    if (v !== 32'h1) begin
      bad++; $display("[TB] FAIL midframe_reset_status: got %h required 00000001", v);
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ja[0] !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("[TB] FAIL midframe_line_idle: %0d low cycles, required 0", lows);
    end
  endtask

  initial begin
    resetModel();
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_rx_overflow();
    test_rx_random();
    test_ignored_window();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
